ca_step_engine: RTL and testbench

//  Datapath end of the en/rst control interface driven by the system FSM.

---
 rtl/ca_step_engine.sv | 151 +++++++++++++++
 tb/tb_ca_step_engine.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ca_step_engine.sv
// ca_step_engine: 1-D cellular-automaton step engine.
// Holds a WIDTH-cell grid and, on each accepted step request, evaluates one
// generation serially (one cell per cycle) using Wolfram rule RULE. It then
// commits the new generation, pulses done and advances gen_count.
// Bit WIDTH-1 is the leftmost cell. Cell i's left neighbour is i+1 and its
// right neighbour is i-1.
// Optional feature macro: CA_WRAP_EN
//   defined   -> toroidal boundary (edge cells see the opposite edge)
//   undefined -> null boundary (out-of-range neighbours read as 0)
// reset_n is the asynchronous chip reset. rst is the controller's synchronous
// clear, and it overrides every other input.

module ca_step_engine #(
    parameter int          WIDTH = 16,
    parameter logic [7:0]  RULE  = 8'd90,
    parameter int          CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             rst,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed,
    output logic [WIDTH-1:0] grid,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] gen_count
);

    localparam int               IDX_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COMPUTE = 2'd1,
        ST_COMMIT  = 2'd2
    } state_t;

    state_t           state_r;
    logic [IDX_W-1:0] idx_r;
    logic [WIDTH-1:0] nxt_r;

    logic [WIDTH-1:0] left_vec_s;
    logic [WIDTH-1:0] right_vec_s;
    logic             edge_left_s;
    logic             edge_right_s;
    logic             left_s;
    logic             centre_s;
    logic             right_s;
    logic             next_cell_s;

    // Look up the rule bit for a 3-cell {left,centre,right} neighbourhood.
    function automatic logic rule_lookup(input logic [7:0] rule_bits,
                                         input logic [2:0] pattern);
        rule_lookup = rule_bits[pattern];
    endfunction

    // Boundary values seen by the edge cells. The grid is read directly,
    // because grid is held stable for the whole of COMPUTE.
    always_comb begin
`ifdef CA_WRAP_EN
        edge_left_s  = grid[0];
        edge_right_s = grid[WIDTH-1];
`else
        edge_left_s  = 1'b0;
        edge_right_s = 1'b0;
`endif
    end

    // Neighbour vectors: left_vec_s[i] is the left neighbour of cell i, and
    // right_vec_s[i] is its right neighbour.
    always_comb begin
        left_vec_s  = {edge_left_s, grid[WIDTH-1:1]};
        right_vec_s = {grid[WIDTH-2:0], edge_right_s};
    end

    // Select the neighbourhood of the cell being evaluated this cycle and
    // apply the rule.
    always_comb begin
        left_s      = left_vec_s[idx_r];
        centre_s    = grid[idx_r];
        right_s     = right_vec_s[idx_r];
        next_cell_s = rule_lookup(RULE, {left_s, centre_s, right_s});
    end

    // Control FSM with registered outputs. rst clears everything and aborts a
    // generation in flight without a done pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r   <= ST_IDLE;
            idx_r     <= '0;
            nxt_r     <= '0;
            grid      <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            gen_count <= '0;
        end else if (rst) begin
            state_r   <= ST_IDLE;
            idx_r     <= '0;
            nxt_r     <= '0;
            grid      <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            gen_count <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (seed_load) begin
                        // A seed load takes priority over a step request.
                        grid      <= seed;
                        gen_count <= '0;
                    end else if (en) begin
                        state_r <= ST_COMPUTE;
                        idx_r   <= '0;
                        busy    <= 1'b1;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_COMPUTE: begin
                    done         <= 1'b0;
                    nxt_r[idx_r] <= next_cell_s;
                    if (idx_r == LAST_IDX) begin
                        idx_r   <= '0;
                        state_r <= ST_COMMIT;
                    end else begin
                        idx_r <= idx_r + IDX_ONE;
                    end
                end
                ST_COMMIT: begin
                    grid      <= nxt_r;
                    gen_count <= gen_count + CNT_ONE;
                    done      <= 1'b1;
                    busy      <= 1'b0;
                    state_r   <= ST_IDLE;
                end
                default: begin
                    // Unreachable encoding: return to a safe idle state.
                    state_r <= ST_IDLE;
                    idx_r   <= '0;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ca_step_engine.sv
// Self-checking bench for ca_step_engine (WIDTH=8, RULE=90, CNT_W=2).
// Every accepted step pushes the generation that the reference model predicts
// onto a queue. A monitor pops one entry and compares it each time done is
// seen high.
`timescale 1ns/1ps
module tb_ca_step_engine;

    localparam int         W   = 8;
    localparam int         CW  = 2;
    localparam logic [7:0] RUL = 8'd90;

    logic          clk;
    logic          reset_n;
    logic          en;
    logic          rst;
    logic          seed_load;
    logic [W-1:0]  seed;
    logic [W-1:0]  grid;
    logic          busy;
    logic          done;
    logic [CW-1:0] gen_count;

    typedef struct packed {
        logic [W-1:0]  g;
        logic [CW-1:0] c;
    } exp_t;

    exp_t          exp_q[$];
    logic [W-1:0]  model_grid;
    logic [CW-1:0] model_cnt;
    int            checks;
    int            errors;
    int            cyc;

    ca_step_engine #(.WIDTH(W), .RULE(RUL), .CNT_W(CW)) dut (
        .clk(clk), .reset_n(reset_n), .en(en), .rst(rst),
        .seed_load(seed_load), .seed(seed), .grid(grid), .busy(busy),
        .done(done), .gen_count(gen_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model of one generation, computed over the whole vector.
    function automatic logic [W-1:0] ca_next(input logic [W-1:0] g);
        logic [7:0]   rv;
        logic [W-1:0] o;
        logic         l, r;
        rv = RUL;
        for (int i = 0; i < W; i++) begin
`ifdef CA_WRAP_EN
            if (i == W-1) l = g[0]; else l = g[i+1];
            if (i == 0) r = g[W-1]; else r = g[i-1];
`else
            if (i == W-1) l = 1'b0; else l = g[i+1];
            if (i == 0) r = 1'b0; else r = g[i-1];
`endif
            o[i] = rv[{l, g[i], r}];
        end
        return o;
    endfunction

    // Scoreboard monitor: each done pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (reset_n && done) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done grid=%b gen_count=%0d", grid, gen_count);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (grid !== e.g || gen_count !== e.c) begin
                    errors++;
                    $display("FAIL sb_generation grid=%b gen_count=%0d required grid=%b gen_count=%0d",
                             grid, gen_count, e.g, e.c);
                end
            end
        end
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic load_seed(input logic [W-1:0] v);
        seed      = v;
        seed_load = 1'b1;
        tick(1);
        seed_load  = 1'b0;
        model_grid = v;
        model_cnt  = '0;
    endtask

    // Predict the next generation and push it onto the scoreboard.
    task automatic push_expect();
        exp_t e;
        model_grid = ca_next(model_grid);
        model_cnt  = model_cnt + 2'd1;
        e.g = model_grid;
        e.c = model_cnt;
        exp_q.push_back(e);
    endtask

    // Pulse en for one edge. Returns busy as sampled just after that edge.
    task automatic step_pulse(input bit expect_done, output logic busy_after);
        if (expect_done) push_expect();
        en = 1'b1;
        tick(1);
        en = 1'b0;
        busy_after = busy;
    endtask

    // Count edges until done is seen high. A return value of 0 means timeout.
    task automatic wait_done(output int n);
        n = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        int   nd;
        logic b;
        reset_n = 1'b0;
        tick(2);
        checks++;
        if (grid !== 8'h00 || busy !== 1'b0 || done !== 1'b0 || gen_count !== 2'd0) begin
            errors++;
            $display("FAIL reset_state grid=%b busy=%b done=%b cnt=%0d required 0", grid, busy, done, gen_count);
        end
        reset_n = 1'b1;
        tick(1);
        load_seed(8'b0101_1010);
        step_pulse(1'b0, b);
        tick(5);
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (grid !== 8'h00 || busy !== 1'b0 || done !== 1'b0 || gen_count !== 2'd0) begin
            errors++;
            $display("FAIL reset_mid_compute grid=%b busy=%b done=%b cnt=%0d required 0", grid, busy, done, gen_count);
        end
        model_grid = '0;
        model_cnt  = '0;
        tick(1);
        reset_n = 1'b1;
        nd = 0;
        for (int i = 0; i < 15; i++) begin
            tick(1);
            if (done) nd++;
        end
        checks++;
        if (nd != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_done done_count=%0d busy=%b required 0 0", nd, busy);
        end
    endtask

    task automatic test_single_step();
        int   n;
        logic b;
        load_seed(8'b0001_0000);
        checks++;
        if (grid !== 8'b0001_0000 || gen_count !== 2'd0) begin
            errors++;
            $display("FAIL seed_load grid=%b cnt=%0d required 00010000 0", grid, gen_count);
        end
        step_pulse(1'b1, b);
        checks++;
        if (b !== 1'b1) begin
            errors++;
            $display("FAIL busy_after_en busy=%b required 1", b);
        end
        tick(4);
        checks++;
        if (grid !== 8'b0001_0000 || busy !== 1'b1) begin
            errors++;
            $display("FAIL grid_stable grid=%b busy=%b required 00010000 1", grid, busy);
        end
        wait_done(n);
        n = (n == 0) ? 0 : n + 4;
        checks++;
        if (n != W+1) begin
            errors++;
            $display("FAIL step_latency edges=%0d required %0d", n, W+1);
        end
        checks++;
        if (grid !== 8'b0010_1000 || gen_count !== 2'd1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL single_step grid=%b cnt=%0d busy=%b required 00101000 1 0", grid, gen_count, busy);
        end
        tick(1);
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL done_one_cycle done=%b required 0", done);
        end
    endtask

    task automatic test_boundary();
        int           n;
        logic         b;
        logic [W-1:0] req;
`ifdef CA_WRAP_EN
        req = 8'b1000_0010;
`else
        req = 8'b0000_0010;
`endif
        load_seed(8'b0000_0001);
        step_pulse(1'b1, b);
        wait_done(n);
        checks++;
        if (n == 0 || grid !== req) begin
            errors++;
            $display("FAIL boundary grid=%b edges=%0d required %b", grid, n, req);
        end
    endtask

    task automatic test_sync_clear();
        int   nd;
        logic b;
        step_pulse(1'b0, b);
        tick(3);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        model_grid = '0;
        model_cnt  = '0;
        checks++;
        if (grid !== 8'h00 || busy !== 1'b0 || gen_count !== 2'd0 || done !== 1'b0) begin
            errors++;
            $display("FAIL sync_clear grid=%b busy=%b cnt=%0d done=%b required 0", grid, busy, gen_count, done);
        end
        nd = 0;
        for (int i = 0; i < 12; i++) begin
            tick(1);
            if (done) nd++;
        end
        checks++;
        if (nd != 0) begin
            errors++;
            $display("FAIL clear_no_done done_count=%0d required 0", nd);
        end
    endtask

    task automatic test_back_to_back();
        int           n;
        int           t[3];
        logic [W-1:0] g1;
        load_seed(8'b0000_1000);
        for (int i = 0; i < 3; i++) push_expect();
        g1 = ca_next(8'b0000_1000);
        en = 1'b1;
        for (int k = 0; k < 3; k++) begin
            if (k == 1) begin
                tick(3);
                seed      = 8'b1111_0000;
                seed_load = 1'b1;
                tick(1);
                seed_load = 1'b0;
                checks++;
                if (grid !== g1 || busy !== 1'b1) begin
                    errors++;
                    $display("FAIL seed_ignored_busy grid=%b busy=%b required %b 1", grid, busy, g1);
                end
            end
            wait_done(n);
            if (n == 0) begin
                errors++;
                $display("FAIL b2b_timeout gen=%0d", k);
            end
            t[k] = cyc;
        end
        en = 1'b0;
        checks++;
        if (t[1] - t[0] != W+2 || t[2] - t[1] != W+2) begin
            errors++;
            $display("FAIL b2b_period gaps=%0d,%0d required %0d", t[1]-t[0], t[2]-t[1], W+2);
        end
        checks++;
        if (gen_count !== 2'd3) begin
            errors++;
            $display("FAIL b2b_count cnt=%0d required 3", gen_count);
        end
        tick(W+4);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_stop busy=%b required 0", busy);
        end
    endtask

    task automatic test_count_wrap();
        int            n;
        int            nd;
        logic          b;
        logic [CW-1:0] req;
        load_seed(8'b0010_0100);
        for (int k = 0; k < 4; k++) begin
            step_pulse(1'b1, b);
            wait_done(n);
            req = CW'(k + 1);
            checks++;
            if (n == 0 || gen_count !== req) begin
                errors++;
                $display("FAIL count_wrap step=%0d cnt=%0d required %0d", k, gen_count, req);
            end
        end
        tick(1);
        seed      = 8'b1100_0011;
        seed_load = 1'b1;
        en        = 1'b1;
        tick(1);
        seed_load = 1'b0;
        en        = 1'b0;
        model_grid = 8'b1100_0011;
        model_cnt  = '0;
        nd = 0;
        for (int i = 0; i < 12; i++) begin
            if (busy || done) nd++;
            tick(1);
        end
        checks++;
        if (grid !== 8'b1100_0011 || gen_count !== 2'd0 || nd != 0) begin
            errors++;
            $display("FAIL seed_over_en grid=%b cnt=%0d active=%0d required 11000011 0 0", grid, gen_count, nd);
        end
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        cyc        = 0;
        reset_n    = 1'b0;
        en         = 1'b0;
        rst        = 1'b0;
        seed_load  = 1'b0;
        seed       = '0;
        model_grid = '0;
        model_cnt  = '0;
        #3;
        test_reset();
        test_single_step();
        test_boundary();
        test_sync_clear();
        test_back_to_back();
        test_count_wrap();
        tick(2);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL missing_done pending=%0d required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
